// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debounce block.
// Channel FSM state encoding and the short debounce interval used in simulation.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        CONF_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        CONF_RELEASE = 2'd3
    } kd_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_SIM = 8;

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: synchroniser, polarity normalisation and counter-qualified FSM.
// Handshake: none; key_o is a level, press_o/release_o are single-cycle pulses aligned with key_o changes.
module debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_i,
    output logic       key_o,
    output logic       press_o,
    output logic       release_o,
    output logic [1:0] state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    kd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_q, key_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // The sample that moves us into a CONF state is itself the first stable
    // sample, so the count starts at one on entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (s) begin
                    state_d = CONF_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            CONF_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    key_d   = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = CONF_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            CONF_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    key_d     = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
                key_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            key_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_o     = key_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign state_o   = state_q;

endmodule

// File: rtl/key_debounce.sv
// Debounce front end for the board keys: one independent channel per key.
// state_dbg_o packs each channel's FSM state, two bits per key, key 0 in the low bits.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned N_KEYS          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_KEYS-1:0]     key_in,
    output logic [N_KEYS-1:0]     key_out,
    output logic [N_KEYS-1:0]     key_press,
    output logic [N_KEYS-1:0]     key_release,
    output logic [2*N_KEYS-1:0]   state_dbg_o
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key_i     (key_in[g]),
            .key_o     (key_out[g]),
            .press_o   (key_press[g]),
            .release_o (key_release[g]),
            .state_o   (state_dbg_o[2*g +: 2])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random key activity
// compared every cycle against a run-length reference model.
module tb_key_debounce;
    import key_debounce_pkg::*;

    localparam int NK = 5;
    localparam int D  = DEBOUNCE_CYCLES_SIM;
    localparam int SS = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NK-1:0]   key_in = '0;
    logic [NK-1:0]   key_out, key_press, key_release;
    logic [2*NK-1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    key_debounce #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4),
        .SYNC_STAGES     (SS),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: a delay line models the synchroniser; the accepted level flips
    // once D consecutive samples disagree with it.
    logic [NK-1:0] pipe [SS];
    logic [NK-1:0] m_out, m_press, m_rel;
    int            run [NK];

    initial begin
        for (int i = 0; i < SS; i++) pipe[i] = '0;
        m_out = '0; m_press = '0; m_rel = '0;
        for (int k = 0; k < NK; k++) run[k] = 0;
    end

    always @(posedge clk) begin
        logic [NK-1:0] s;
        m_press = '0;
        m_rel   = '0;
        if (rst) begin
            for (int i = 0; i < SS; i++) pipe[i] = '0;
            m_out = '0;
            for (int k = 0; k < NK; k++) run[k] = 0;
        end else begin
            s = pipe[SS-1];
            for (int i = SS-1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = ~key_in;
            for (int k = 0; k < NK; k++) begin
                if (s[k] != m_out[k]) begin
                    run[k]++;
                    if (run[k] == D) begin
                        m_out[k] = s[k];
                        if (s[k]) m_press[k] = 1'b1;
                        else      m_rel[k]   = 1'b1;
                        run[k] = 0;
                    end
                end else begin
                    run[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("key_out", 32'(key_out), 32'(m_out));
            check("key_press", 32'(key_press), 32'(m_press));
            check("key_release", 32'(key_release), 32'(m_rel));
            check("press_and_release", 32'(key_press & key_release), 32'd0);
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts clk edges after the current drive point until key_out matches want under mask.
    task automatic measure(input string tag, input logic [NK-1:0] mask, input logic [NK-1:0] want);
        int n;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if ((key_out & mask) == want) begin
                n = i;
                break;
            end
        end
        check(tag, 32'(n), 32'(SS + D));
    endtask

    initial begin
        int hold [NK];

        // Reset with every key held pressed
        rst = 1'b1;
        key_in = '0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        check("reset_key_out", 32'(key_out), 32'd0);
        run_cycles(2);
        rst = 1'b0;
        measure("reset_release_latency", 5'h1f, 5'h1f);
        key_in = 5'h1f;
        run_cycles(15);

        // Clean press and release on key 0
        key_in[0] = 1'b0;
        measure("clean_press_latency", 5'h01, 5'h01);
        run_cycles(10);
        key_in[0] = 1'b1;
        measure("clean_release_latency", 5'h01, 5'h00);
        run_cycles(12);

        // Bounce on key 1, then held low
        for (int i = 0; i < 4; i++) begin
            key_in[1] = i[0];
            run_cycles(3);
        end
        key_in[1] = 1'b0;
        measure("bounce_press_latency", 5'h02, 5'h02);
        key_in[1] = 1'b1;
        run_cycles(15);

        // Glitch of D-1 cycles rejected, D cycles accepted
        key_in[2] = 1'b0;
        run_cycles(D - 1);
        key_in[2] = 1'b1;
        run_cycles(15);
        check("glitch_rejected", 32'(key_out[2]), 32'd0);
        key_in[2] = 1'b0;
        run_cycles(D);
        key_in[2] = 1'b1;
        run_cycles(2);
        check("min_pulse_accepted", 32'(key_out[2]), 32'd1);
        run_cycles(15);

        // Independence of keys 3 and 4
        key_in[4:3] = 2'b00;
        run_cycles(5);
        key_in[3] = 1'b1;
        run_cycles(7);
        check("indep_key4", 32'(key_out[4:3]), 32'b10);
        key_in[4] = 1'b1;
        run_cycles(15);

        // Reset mid-confirm on key 0
        key_in[0] = 1'b0;
        run_cycles(7);
        rst = 1'b1;
        run_cycles(1);
        rst = 1'b0;
        measure("reset_requalify_latency", 5'h01, 5'h01);
        key_in[0] = 1'b1;
        run_cycles(15);

        // Random activity with occasional resets
        for (int k = 0; k < NK; k++) hold[k] = $urandom_range(1, 14);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    hold[k] = $urandom_range(1, 14);
                end else begin
                    hold[k]--;
                end
            end
            rst = ($urandom_range(0, 599) == 0);
            run_cycles(1);
        end
        rst = 1'b0;
        run_cycles(5);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
